l1d_fill_unit: RTL and testbench

// - Miss/refill engine directly downstream of the L1 data cache. Accepts line misses (tag, set), merges duplicates,

---
 rtl/l1d_fill_unit_pkg.sv | 24 ++
 rtl/l1d_fill_unit_match.sv | 23 ++
 rtl/l1d_fill_unit.sv | 149 ++++++++++++++
 tb/tb_l1d_fill_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1d_fill_unit_pkg.sv
// Shared types for the L1D fill unit: word/line/tag/set types and fill-buffer entry state.
package L1DPkg;

  localparam int unsigned L1D_OFFSET_BITS = 2;
  localparam int unsigned L1D_SET_BITS    = 5;
  localparam int unsigned L1D_ADDR_BITS   = 30;
  localparam int unsigned L1D_LFB_SZ_EXP  = 3;
  localparam int unsigned L1D_WORDS       = 2 ** L1D_OFFSET_BITS;
  localparam int unsigned L1D_TAG_BITS    = L1D_ADDR_BITS - L1D_SET_BITS - L1D_OFFSET_BITS;

  typedef logic [31:0]              w_t;
  typedef logic [L1D_TAG_BITS-1:0]  tag_t;
  typedef logic [L1D_SET_BITS-1:0]  set_t;
  typedef w_t   [L1D_WORDS-1:0]     line_t;

  typedef enum logic [1:0] {FREE, PENDING, ISSUED} lfb_state_e;

  typedef struct packed {
    lfb_state_e state;
    tag_t       tag;
    set_t       set;
  } lfb_entry_t;

endpackage

// File: rtl/l1d_fill_unit_match.sv
// Combinational N-way CAM over fill-buffer keys; one entry index may be masked out.
module lfb_match #(
  parameter int unsigned N     = 8,
  parameter int unsigned KEY_W = 28,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]            live,
  input  logic [N-1:0][KEY_W-1:0] keys,
  input  logic                    excl_en,
  input  logic [IDX_W-1:0]        excl_idx,
  input  logic [KEY_W-1:0]        key,
  output logic                    hit
);

  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (live[i] && (keys[i] == key) && !(excl_en && (excl_idx == IDX_W'(i))))
        hit = 1'b1;
    end
  end

endmodule

// File: rtl/l1d_fill_unit.sv
// L1D miss/refill engine: merges duplicate misses, issues in-order line reads,
// assembles returned beats and pulses each completed line to the cache array.
module l1d_fill_unit
  import L1DPkg::*;
#(
  parameter int unsigned OFFSET_BITS = L1D_OFFSET_BITS,
  parameter int unsigned SET_BITS    = L1D_SET_BITS,
  parameter int unsigned ADDR_BITS   = L1D_ADDR_BITS,
  parameter int unsigned LFB_SZ_EXP  = L1D_LFB_SZ_EXP
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      missValid,
  output logic                                      missReady,
  input  logic [ADDR_BITS-SET_BITS-OFFSET_BITS-1:0] missTag,
  input  logic [SET_BITS-1:0]                       missSet,
  input  logic [ADDR_BITS-SET_BITS-OFFSET_BITS-1:0] probeTag,
  input  logic [SET_BITS-1:0]                       probeSet,
  output logic                                      probeHit,
  output logic                                      memReqValid,
  input  logic                                      memReqReady,
  output logic [ADDR_BITS-OFFSET_BITS-1:0]          memReqAddr,
  input  logic                                      memRespValid,
  input  w_t                                        memRespData,
  output logic                                      fillValid,
  output logic [ADDR_BITS-SET_BITS-OFFSET_BITS-1:0] fillTag,
  output logic [SET_BITS-1:0]                       fillSet,
  output logic [(2**OFFSET_BITS)*32-1:0]            fillLine
);

  localparam int unsigned WORDS  = 2 ** OFFSET_BITS;
  localparam int unsigned KEY_W  = ADDR_BITS - OFFSET_BITS;
  localparam int unsigned LFB_SZ = 2 ** LFB_SZ_EXP;
  localparam logic [LFB_SZ_EXP:0] FULL = (LFB_SZ_EXP + 1)'(LFB_SZ);

  typedef logic [LFB_SZ_EXP-1:0] ptr_t;

  lfb_state_e                  state_q [LFB_SZ];
  lfb_state_e                  state_n [LFB_SZ];
  logic [LFB_SZ-1:0][KEY_W-1:0] key_q, key_n;
  logic [LFB_SZ-1:0]           live;
  ptr_t                        alloc_ptr, issue_ptr, retire_ptr, issue_ptr_n, beat_ptr;
  logic [LFB_SZ_EXP:0]         count;
  logic [OFFSET_BITS-1:0]      beat;
  w_t [WORDS-1:0]              line_acc, line_n;
  logic                        req_valid_q;
  logic [KEY_W-1:0]            req_addr_q;
  logic                        fill_valid_q;
  logic [KEY_W-1:0]            fill_key_q;
  w_t [WORDS-1:0]              fill_line_q;
  logic [KEY_W-1:0]            miss_key, probe_key;
  logic                        merge_hit, alloc, req_fire, retiring, last_beat;

  assign miss_key  = {missTag, missSet};
  assign probe_key = {probeTag, probeSet};
  assign missReady = (count != FULL);
  assign retiring  = fill_valid_q;
  assign alloc     = missValid && missReady && !merge_hit;
  assign req_fire  = req_valid_q && memReqReady;
  assign last_beat = memRespValid && (beat == OFFSET_BITS'(WORDS - 1));
  // During the fill cycle the retiring line is already latched, so new beats target the next entry.
  assign beat_ptr  = retire_ptr + ptr_t'(retiring);

  always_comb begin
    for (int unsigned i = 0; i < LFB_SZ; i++)
      live[i] = (state_q[i] != FREE);
  end

  lfb_match #(.N(LFB_SZ), .KEY_W(KEY_W), .IDX_W(LFB_SZ_EXP)) u_merge_cam (
    .live(live), .keys(key_q), .excl_en(retiring), .excl_idx(retire_ptr),
    .key(miss_key), .hit(merge_hit)
  );

  lfb_match #(.N(LFB_SZ), .KEY_W(KEY_W), .IDX_W(LFB_SZ_EXP)) u_probe_cam (
    .live(live), .keys(key_q), .excl_en(retiring), .excl_idx(retire_ptr),
    .key(probe_key), .hit(probeHit)
  );

  always_comb begin
    state_n     = state_q;
    key_n       = key_q;
    issue_ptr_n = issue_ptr;
    if (req_fire) begin
      state_n[issue_ptr] = ISSUED;
      issue_ptr_n        = issue_ptr + ptr_t'(1);
    end
    if (alloc) begin
      state_n[alloc_ptr] = PENDING;
      key_n[alloc_ptr]   = miss_key;
    end
    if (retiring)
      state_n[retire_ptr] = FREE;
    line_n = line_acc;
    if (memRespValid)
      line_n[beat] = memRespData;
  end

  // Lines retire strictly in order, so one assembly register serves whichever entry is at the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= '{default: FREE};
      key_q        <= '0;
      alloc_ptr    <= '0;
      issue_ptr    <= '0;
      retire_ptr   <= '0;
      count        <= '0;
      beat         <= '0;
      line_acc     <= '0;
      req_valid_q  <= 1'b0;
      req_addr_q   <= '0;
      fill_valid_q <= 1'b0;
      fill_key_q   <= '0;
      fill_line_q  <= '0;
    end else begin
      state_q   <= state_n;
      key_q     <= key_n;
      issue_ptr <= issue_ptr_n;
      if (alloc)
        alloc_ptr <= alloc_ptr + ptr_t'(1);
      if (retiring)
        retire_ptr <= retire_ptr + ptr_t'(1);
      case ({alloc, retiring})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (memRespValid)
        beat <= beat + 1'b1;
      line_acc     <= line_n;
      req_valid_q  <= (state_n[issue_ptr_n] == PENDING);
      req_addr_q   <= key_n[issue_ptr_n];
      fill_valid_q <= last_beat;
      if (last_beat) begin
        fill_key_q  <= key_q[beat_ptr];
        fill_line_q <= line_n;
      end
    end
  end

  assign memReqValid        = req_valid_q;
  assign memReqAddr         = req_addr_q;
  assign fillValid          = fill_valid_q;
  assign {fillTag, fillSet} = fill_key_q;
  assign fillLine           = fill_line_q;

  a_beat_to_issued: assert property (@(posedge clk) disable iff (rst)
    memRespValid |-> (state_q[beat_ptr] == ISSUED));

endmodule

// File: tb/tb_l1d_fill_unit.sv
// Randomized scoreboard bench for l1d_fill_unit with a queue-based reference model.
module tb_l1d_fill_unit;

  typedef logic [27:0] key_t;
  typedef struct packed {
    key_t         key;
    logic [127:0] line;
  } fill_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         missValid = 1'b0, missReady;
  logic [22:0]  missTag = '0, probeTag = '0, fillTag;
  logic [4:0]   missSet = '0, probeSet = '0, fillSet;
  logic         probeHit, memReqValid, memReqReady = 1'b0, memRespValid = 1'b0, fillValid;
  logic [27:0]  memReqAddr;
  logic [31:0]  memRespData = '0;
  logic [127:0] fillLine;

  always #5 clk = ~clk;

  l1d_fill_unit #(.OFFSET_BITS(2), .SET_BITS(5), .ADDR_BITS(30), .LFB_SZ_EXP(3)) dut (
    .clk(clk), .rst(rst),
    .missValid(missValid), .missReady(missReady), .missTag(missTag), .missSet(missSet),
    .probeTag(probeTag), .probeSet(probeSet), .probeHit(probeHit),
    .memReqValid(memReqValid), .memReqReady(memReqReady), .memReqAddr(memReqAddr),
    .memRespValid(memRespValid), .memRespData(memRespData),
    .fillValid(fillValid), .fillTag(fillTag), .fillSet(fillSet), .fillLine(fillLine)
  );

  // Reference model: lines in flight in allocation order, plus expectation queues.
  key_t        inflight[$];
  key_t        exp_req[$];
  key_t        issue_q[$];
  fill_t       exp_fill[$];
  fill_t       burst_q[$];
  logic [31:0] forced_data[$];
  key_t        miss_q[$];
  key_t        fill_miss_q[$];
  int unsigned beat_idx = 0;
  bit          fill_now = 1'b0;
  bit          miss_src = 1'b0;
  bit          probe_fixed = 1'b0;
  key_t        probe_key = '0;
  int unsigned ready_pct = 100, resp_pct = 100, miss_pct = 100;
  int          errors = 0, checks = 0;
  int          reqs_seen = 0, fills_seen = 0;

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic key_t mk(input logic [22:0] t, input logic [4:0] s);
    return {t, s};
  endfunction

  function automatic bit in_flight(input key_t k, input bit excl_front);
    for (int i = 0; i < inflight.size(); i++)
      if (!(excl_front && i == 0) && inflight[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  // One clock of the reference model: evaluate mid-cycle, then drive next inputs after the edge.
  task automatic cycle();
    key_t  k;
    fill_t f;
    bit    nf;
    bit    exp_ready;
    @(negedge clk);
    if (rst) begin
      inflight.delete(); exp_req.delete(); issue_q.delete();
      exp_fill.delete(); burst_q.delete();
      beat_idx = 0;
      fill_now = 1'b0;
    end else begin
      exp_ready = (inflight.size() != 8);
      chk_b("missReady", missReady, exp_ready);
      chk_b("probeHit", probeHit, in_flight({probeTag, probeSet}, fill_now));
      chk_b("fillValid", fillValid, fill_now);
      if (missValid && exp_ready) begin
        k = {missTag, missSet};
        if (!in_flight(k, fill_now)) begin
          inflight.push_back(k);
          exp_req.push_back(k);
          issue_q.push_back(k);
        end
        if (miss_src) void'(fill_miss_q.pop_front());
        else          void'(miss_q.pop_front());
      end
      if (fill_now && inflight.size() > 0) void'(inflight.pop_front());
      if (memReqValid && memReqReady && issue_q.size() > 0) begin
        f.key = issue_q.pop_front();
        for (int w = 0; w < 4; w++)
          f.line[32*w +: 32] = (forced_data.size() > 0) ? forced_data.pop_front() : $urandom;
        burst_q.push_back(f);
        exp_fill.push_back(f);
      end
      nf = 1'b0;
      if (memRespValid) begin
        beat_idx++;
        if (beat_idx == 4) begin
          beat_idx = 0;
          void'(burst_q.pop_front());
          nf = 1'b1;
        end
      end
      fill_now = nf;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      missValid    = 1'b0;
      memReqReady  = 1'b0;
      memRespValid = 1'b0;
    end else begin
      miss_src  = 1'b0;
      missValid = 1'b0;
      if (fill_now && fill_miss_q.size() > 0) begin
        missValid          = 1'b1;
        miss_src           = 1'b1;
        {missTag, missSet} = fill_miss_q[0];
      end else if (miss_q.size() > 0 && $urandom_range(99) < miss_pct) begin
        missValid          = 1'b1;
        {missTag, missSet} = miss_q[0];
      end else begin
        {missTag, missSet} = key_t'($urandom);
      end
      memReqReady  = ($urandom_range(99) < ready_pct);
      memRespValid = (burst_q.size() > 0) && ($urandom_range(99) < resp_pct);
      memRespData  = memRespValid ? burst_q[0].line[32*beat_idx +: 32] : $urandom;
      if (probe_fixed)
        {probeTag, probeSet} = probe_key;
      else if (inflight.size() > 0 && $urandom_range(1) == 1)
        {probeTag, probeSet} = inflight[$urandom % inflight.size()];
      else
        {probeTag, probeSet} = key_t'($urandom);
    end
  endtask

  task automatic run_idle(input string name, input int budget);
    int n = 0;
    while ((miss_q.size() > 0 || fill_miss_q.size() > 0 || inflight.size() > 0 || fill_now)
           && n < budget) begin
      cycle();
      n++;
    end
    chk_b({name, "_timeout"}, (n < budget), 1'b1);
    chk_w({name, "_req_drain"}, 128'(exp_req.size()), 128'd0);
    chk_w({name, "_fill_drain"}, 128'(exp_fill.size()), 128'd0);
  endtask

  task automatic reset_checks(input string name);
    @(negedge clk);
    chk_b({name, "_missReady"}, missReady, 1'b1);
    chk_b({name, "_memReqValid"}, memReqValid, 1'b0);
    chk_b({name, "_fillValid"}, fillValid, 1'b0);
    chk_b({name, "_probeHit"}, probeHit, 1'b0);
  endtask

  task automatic enter_reset();
    rst          = 1'b1;
    missValid    = 1'b0;
    memReqReady  = 1'b0;
    memRespValid = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT presents a request or a fill.
  always @(negedge clk) begin
    fill_t f;
    if (!rst) begin
      if (memReqValid && memReqReady) begin
        reqs_seen++;
        if (exp_req.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL memReq: got request addr %0h expected no request", memReqAddr);
        end else begin
          chk_w("memReqAddr", 128'(memReqAddr), 128'(exp_req.pop_front()));
        end
      end
      if (fillValid) begin
        fills_seen++;
        if (exp_fill.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fill: got fill tag %0h set %0h expected no fill", fillTag, fillSet);
        end else begin
          f = exp_fill.pop_front();
          chk_w("fillTag", 128'(fillTag), 128'(f.key[27:5]));
          chk_w("fillSet", 128'(fillSet), 128'(f.key[4:0]));
          chk_w("fillLine", fillLine, f.line);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   r0, f0, n;
    key_t k;

    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    reset_checks("por");

    // Single miss with known data.
    r0 = reqs_seen; f0 = fills_seen;
    forced_data = '{32'h11, 32'h22, 32'h33, 32'h44};
    miss_q.push_back(mk(23'h12345, 5'd3));
    run_idle("single", 200);
    chk_w("single_reqs", 128'(reqs_seen - r0), 128'd1);
    chk_w("single_fills", 128'(fills_seen - f0), 128'd1);

    // Same line missed three times before any data returns.
    r0 = reqs_seen; f0 = fills_seen;
    resp_pct = 0;
    probe_fixed = 1'b1;
    probe_key = mk(23'h7, 5'd1);
    repeat (3) miss_q.push_back(mk(23'h7, 5'd1));
    repeat (12) cycle();
    resp_pct = 100;
    run_idle("merge", 200);
    chk_w("merge_reqs", 128'(reqs_seen - r0), 128'd1);
    chk_w("merge_fills", 128'(fills_seen - f0), 128'd1);
    probe_fixed = 1'b0;

    // Fill the buffer with memory stalled; the ninth miss must wait for a retire.
    r0 = reqs_seen; f0 = fills_seen;
    ready_pct = 0;
    for (int i = 0; i < 9; i++) miss_q.push_back(mk(23'(32'h100 + i), 5'(i)));
    repeat (15) cycle();
    chk_w("full_stall_9th", 128'(miss_q.size()), 128'd1);
    chk_b("full_missReady", missReady, 1'b0);
    ready_pct = 100;
    run_idle("full", 400);
    chk_w("full_reqs", 128'(reqs_seen - r0), 128'd9);
    chk_w("full_fills", 128'(fills_seen - f0), 128'd9);

    // Twenty distinct misses with random gaps on every interface.
    r0 = reqs_seen; f0 = fills_seen;
    ready_pct = 50; resp_pct = 70; miss_pct = 60;
    for (int i = 0; i < 20; i++)
      miss_q.push_back(mk(23'((i + 1) * 256 + $urandom_range(255)), 5'($urandom)));
    run_idle("rand", 3000);
    chk_w("rand_reqs", 128'(reqs_seen - r0), 128'd20);
    chk_w("rand_fills", 128'(fills_seen - f0), 128'd20);
    ready_pct = 100; resp_pct = 100; miss_pct = 100;

    // A miss to the line being filled, presented in its own fill cycle, re-allocates.
    r0 = reqs_seen; f0 = fills_seen;
    k = mk(23'h9, 5'd5);
    miss_q.push_back(k);
    fill_miss_q.push_back(k);
    run_idle("refill", 300);
    chk_w("refill_reqs", 128'(reqs_seen - r0), 128'd2);
    chk_w("refill_fills", 128'(fills_seen - f0), 128'd2);

    // Reset in the middle of a burst, then a fresh miss.
    k = mk(23'h55, 5'h1a);
    probe_fixed = 1'b1;
    probe_key = k;
    miss_q.push_back(k);
    n = 0;
    while (!(beat_idx == 2 && burst_q.size() > 0) && n < 100) begin
      cycle();
      n++;
    end
    chk_b("midburst_reach", (n < 100), 1'b1);
    enter_reset();
    reset_checks("midburst");
    probe_fixed = 1'b0;
    r0 = reqs_seen; f0 = fills_seen;
    miss_q.push_back(mk(23'h66, 5'd2));
    run_idle("post_reset", 200);
    chk_w("post_reset_reqs", 128'(reqs_seen - r0), 128'd1);
    chk_w("post_reset_fills", 128'(fills_seen - f0), 128'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
